ram2_bist: RTL and testbench

RAM2_BIST -- requirements
Module: ram2_bist

---
 rtl/ram2_bist.sv | 131 +++++++++++++
 tb/tb_ram2_bist.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram2_bist.sv
// March-style write/read-back BIST for a single-port 32-bit RAM on a shared data bus.
// Writes SEED+addr to every word, turns the bus around, then reads and checks each word.
module ram2_bist #(
    parameter int unsigned DEPTH = 32,
    parameter logic [31:0] SEED  = 32'd128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ena,
    output logic        wena,
    output logic [4:0]  addr,
    inout  wire  [31:0] data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  err_count,
    output logic [4:0]  err_addr
);

    localparam logic [4:0] LAST = 5'(DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StTurn,
        StRdAddr,
        StRdChk,
        StDone
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        drive;
    logic [31:0] pattern;
    logic        mismatch;
    logic [5:0]  err_inc;
    logic [5:0]  err_next;

    assign pattern  = SEED + {27'd0, addr};
    assign data     = drive ? pattern : {32{1'bz}};
    assign mismatch = (data != pattern);
    assign err_inc  = (err_count == 6'd63) ? err_count : err_count + 6'd1;
    assign err_next = mismatch ? err_inc : err_count;

    // All outputs are registers; the bus enable only ever rises on entry to StWrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            ena       <= 1'b0;
            wena      <= 1'b0;
            addr      <= '0;
            drive     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state     <= StWrite;
                        cnt       <= '0;
                        addr      <= '0;
                        ena       <= 1'b1;
                        wena      <= 1'b1;
                        drive     <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        err_addr  <= '0;
                    end
                end
                StWrite: begin
                    if (cnt == LAST) begin
                        state <= StTurn;
                        cnt   <= '0;
                        addr  <= '0;
                        ena   <= 1'b0;
                        wena  <= 1'b0;
                        drive <= 1'b0;
                    end else begin
                        cnt  <= cnt + 5'd1;
                        addr <= cnt + 5'd1;
                    end
                end
                StTurn: begin
                    state <= StRdAddr;
                    ena   <= 1'b1;
                end
                StRdAddr: begin
                    state <= StRdChk;
                end
                StRdChk: begin
                    // Sampling at the end of StRdChk suits both flow-through and registered RAMs.
                    if (mismatch) begin
                        err_count <= err_inc;
                        if (err_count == 6'd0) begin
                            err_addr <= addr;
                        end
                    end
                    if (cnt < LAST) begin
                        state <= StRdAddr;
                        cnt   <= cnt + 5'd1;
                        addr  <= cnt + 5'd1;
                    end else begin
                        state <= StDone;
                        ena   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 6'd0);
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    a_drive_only_in_write: assert property (
        @(posedge clk) disable iff (!rst_n) drive |-> (state == StWrite));
    a_turn_idle_bus: assert property (
        @(posedge clk) disable iff (!rst_n) (state == StTurn) |-> !ena);
    a_busy_done_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n) !(busy && done));

endmodule

// File: tb/tb_ram2_bist.sv
// Bench for ram2_bist: behavioural RAM (flow-through or registered read) with fault masks,
// two DUTs (SEED 128 and a wrapping SEED), per-cycle protocol model and a result scoreboard.
module tb_ram2_bist;

    localparam int D = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic start_a, start_w;
    logic sel, reg_rd, probe;

    wire  [31:0] data_a, data_w;
    logic        ena_a, wena_a, busy_a, done_a, pass_a;
    logic        ena_w, wena_w, busy_w, done_w, pass_w;
    logic [4:0]  addr_a, eaddr_a, addr_w, eaddr_w;
    logic [5:0]  ecnt_a, ecnt_w;

    int total = 0;
    int bad   = 0;

    ram2_bist #(.DEPTH(32), .SEED(32'd128)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .ena(ena_a), .wena(wena_a),
        .addr(addr_a), .data(data_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(ecnt_a), .err_addr(eaddr_a)
    );

    ram2_bist #(.DEPTH(32), .SEED(32'hFFFF_FFF0)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .ena(ena_w), .wena(wena_w),
        .addr(addr_w), .data(data_w), .busy(busy_w), .done(done_w), .pass(pass_w),
        .err_count(ecnt_w), .err_addr(eaddr_w)
    );

    initial forever #5 clk = ~clk;

    // View of whichever DUT is currently attached to the RAM.
    wire        ena   = sel ? ena_w   : ena_a;
    wire        wena  = sel ? wena_w  : wena_a;
    wire [4:0]  addr  = sel ? addr_w  : addr_a;
    wire        busy  = sel ? busy_w  : busy_a;
    wire        done  = sel ? done_w  : done_a;
    wire        pass  = sel ? pass_w  : pass_a;
    wire [5:0]  ecnt  = sel ? ecnt_w  : ecnt_a;
    wire [4:0]  eaddr = sel ? eaddr_w : eaddr_a;
    wire [31:0] bus   = sel ? data_w  : data_a;

    logic [31:0] mem   [D];
    logic [31:0] and_m [D];
    logic [31:0] or_m  [D];
    logic [31:0] rd_q;
    logic        rd_oe_q;

    always @(posedge clk) begin
        if (ena && wena) mem[addr] <= (bus & and_m[addr]) | or_m[addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_oe_q <= 1'b0;
        end else begin
            rd_oe_q <= ena && !wena;
            rd_q    <= mem[addr];
        end
    end

    wire        ram_oe  = reg_rd ? rd_oe_q : (ena && !wena);
    wire [31:0] ram_out = reg_rd ? rd_q : mem[addr];

    // probe pulls the bus to 0 where the BIST must be high-Z, so a stray driver shows up.
    assign data_a = (!sel && ram_oe) ? ram_out : ((!sel && probe) ? 32'h0 : {32{1'bz}});
    assign data_w = ( sel && ram_oe) ? ram_out : (( sel && probe) ? 32'h0 : {32{1'bz}});

    typedef struct {
        logic       sel;
        logic       reg_rd;
        logic       hold;
        int         fault;
        logic       exp_pass;
        logic [5:0] exp_cnt;
        logic [4:0] exp_addr;
    } vec_t;

    typedef struct packed {
        logic       pass;
        logic [5:0] cnt;
        logic [4:0] ea;
    } res_t;

    vec_t        vecs [7];
    logic [31:0] wr_q [$];
    res_t        res_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {52'd0, ena, wena, addr, busy, done, pass, ecnt, eaddr}, 64'd0);
        check({name, "_bus"}, {32'd0, bus}, 64'd0);
    endtask

    task automatic run(input vec_t v, input int abort_at);
        logic [31:0] seed;
        logic [31:0] e;
        res_t        r;
        logic        e_ena, e_wena, e_busy, e_done, rd_chk;
        logic [4:0]  e_addr, g_addr;
        int          j;
        sel    = v.sel;
        reg_rd = v.reg_rd;
        for (int i = 0; i < D; i++) begin
            and_m[i] = 32'hFFFF_FFFF;
            or_m[i]  = 32'h0;
        end
        case (v.fault)
            1: and_m[5] = ~32'h1;
            2: begin
                or_m[3]  = 32'h8000_0000;
                or_m[7]  = 32'h8000_0000;
                or_m[20] = 32'h8000_0000;
            end
            3: for (int i = 0; i < D; i++) or_m[i] = 32'h8000_0000;
            default: ;
        endcase
        seed = v.sel ? 32'hFFFF_FFF0 : 32'd128;
        for (int i = 0; i < D; i++) wr_q.push_back(seed + 32'(i));
        res_q.push_back({v.exp_pass, v.exp_cnt, v.exp_addr});
        r = '0;
        if (v.sel) start_w = 1'b1;
        else start_a = 1'b1;

        for (int k = 0; k <= 3 * D + 2; k++) begin
            @(posedge clk);
            #1;
            probe = (k == D) || (k == 3 * D + 2);
            if ((k == 0 && !v.hold) || k == D) begin
                start_a = 1'b0;
                start_w = 1'b0;
            end
            @(negedge clk);
            rd_chk = 1'b0;
            if (k < D) begin
                {e_ena, e_wena, e_addr, e_busy, e_done} = {2'b11, 5'(k), 2'b10};
            end else if (k == D) begin
                {e_ena, e_wena, e_addr, e_busy, e_done} = {2'b00, 5'd0, 2'b10};
            end else if (k <= 3 * D) begin
                j = (k - D - 1) / 2;
                rd_chk = ((k - D - 1) % 2) == 1;
                {e_ena, e_wena, e_addr, e_busy, e_done} = {2'b10, 5'(j), 2'b10};
            end else begin
                {e_ena, e_wena, e_addr, e_busy, e_done} = {2'b00, 5'd0, 2'b01};
            end
            g_addr = (k == D || k > 3 * D) ? 5'd0 : addr;
            check("cycle",
                  {53'd0, ena, wena, g_addr, busy, done, ram_oe && ena && wena,
                   rd_chk && $isunknown(bus)},
                  {53'd0, e_ena, e_wena, e_addr, e_busy, e_done, 2'b00});
            if (k < D) begin
                e = wr_q.pop_front();
                check("wdata", {32'd0, bus}, {32'd0, e});
            end
            if (probe) check("bus_z", {32'd0, bus}, 64'd0);
            if (k == 3 * D + 1) begin
                r = res_q.pop_front();
                check("result", {52'd0, pass, ecnt, eaddr}, {52'd0, r});
            end
            if (k == 3 * D + 2) check("done_hold", {52'd0, done, pass, ecnt, eaddr}, {52'd0, 1'b1, r});
            if (k == abort_at) begin
                rst_n = 1'b0;
                probe = 1'b1;
                #1;
                check_reset_outputs("abort");
                wr_q.delete();
                res_q.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_reset_outputs("post_abort");
                probe = 1'b0;
                return;
            end
        end
        probe = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_w = 1'b0;
        sel     = 1'b0;
        reg_rd  = 1'b0;
        probe   = 1'b1;
        for (int i = 0; i < D; i++) begin
            and_m[i] = 32'hFFFF_FFFF;
            or_m[i]  = 32'h0;
        end

        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("idle");
        end
        probe = 1'b0;

        //        sel   reg   hold  fault pass  cnt    addr
        vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, 6'd0,  5'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 0, 1'b1, 6'd0,  5'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, 6'd1,  5'd5};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 6'd3,  5'd3};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 3, 1'b0, 6'd32, 5'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, 6'd0,  5'd0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 6'd1,  5'd5};

        for (int i = 0; i < 7; i++) run(vecs[i], -1);

        // Abort during RD_ADDR of word 10 (cycle D+1+2*10), then a clean run from IDLE.
        run(vecs[0], D + 1 + 20);
        run(vecs[0], -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
